// File: rtl/ppi_pkg.sv
// ppi_pkg: shared constants and types for the ppi_hs parallel port block.
// Holds register addresses, the control-word layout, the reset mode value,
// the port C handshake bit positions and small decode helpers.
package ppi_pkg;

    // Host register addresses
    localparam logic [1:0] ADDR_PA   = 2'd0;
    localparam logic [1:0] ADDR_PB   = 2'd1;
    localparam logic [1:0] ADDR_PC   = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    // Mode register value after reset: all ports input, both groups mode 0
    localparam logic [7:0] RST_MODE_DEF = 8'h9B;

    // Control word: bit 7 selects mode set (1) or port C bit set/reset (0)
    localparam int unsigned CW_SEL_BIT = 7;

    // Port C handshake bit positions
    localparam int unsigned PC_INTR_B = 0;  // group B INTR
    localparam int unsigned PC_HS_B   = 1;  // group B IBF / OBF_n
    localparam int unsigned PC_STB_B  = 2;  // group B STB_n / ACK_n
    localparam int unsigned PC_INTR_A = 3;  // group A INTR
    localparam int unsigned PC_STB_A  = 4;  // group A STB_n (input)
    localparam int unsigned PC_IBF_A  = 5;  // group A IBF (input)
    localparam int unsigned PC_ACK_A  = 6;  // group A ACK_n (output)
    localparam int unsigned PC_OBF_A  = 7;  // group A OBF_n (output)

    // Mode-set control word; a direction bit of 1 means input
    typedef struct packed {
        logic       sel;     // always 1 for a mode set
        logic [1:0] a_mode;  // 00 = mode 0, anything else = mode 1
        logic       pa_in;
        logic       pch_in;  // PC[7:4]
        logic       b_mode;
        logic       pb_in;
        logic       pcl_in;  // PC[3:0]
    } mode_word_t;

    // Group A handshake mode decode
    function automatic logic grp_a_mode1(input mode_word_t m);
        return |m.a_mode;
    endfunction

    // Bit set/reset: port C bit index carried in cw[3:1]
    function automatic logic [2:0] bsr_bit_idx(input logic [7:0] cw);
        return cw[3:1];
    endfunction

endpackage

// File: rtl/ppi_hs_if.sv
// ppi_hs_if: host bus of the ppi_hs block.
//   cs_n, rd_n, wr_n : active-low chip select / read / write strobes
//   a                : register select (PA, PB, PC, control)
//   din              : host write data
//   dout, dout_oe    : registered read data and bus drive enable
interface ppi_hs_if #(
    parameter int unsigned W = 8
);
    logic         cs_n;
    logic         rd_n;
    logic         wr_n;
    logic [1:0]   a;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         dout_oe;

    // Host side
    modport master (
        output cs_n, rd_n, wr_n, a, din,
        input  dout, dout_oe
    );

    // Peripheral side
    modport slave (
        input  cs_n, rd_n, wr_n, a, din,
        output dout, dout_oe
    );
endinterface

// File: rtl/ppi_hs_chan.sv
// ppi_hs_chan: one handshake channel (port A or port B group).
// Owns the port data latch, INTE, IBF, OBF_n and INTR, and edge-detects the
// STB_n / ACK_n pin. In mode 0 it is just the port output latch.
//   clk, reset     : clock and synchronous active-high reset
//   mode1, dir_in  : group in handshake mode; port is an input
//   clr            : mode set, abandons any handshake
//   port_wr        : host write event to this port, data on wr_data
//   rd_start       : host read start on this port
//   rd_end         : host read end on this port
//   hs_in_n        : STB_n (input) or ACK_n (output) pin
//   inte_wr        : bit set/reset aimed at this channel's INTE
//   inte_val       : value written to INTE
//   port_in        : port pin inputs
//   latch          : data latch (drives the port pins)
//   ibf, obf_n     : buffer-full flags
//   intr, inte     : interrupt request and enable
module ppi_hs_chan
    import ppi_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mode1,
    input  logic         dir_in,
    input  logic         clr,
    input  logic         port_wr,
    input  logic [W-1:0] wr_data,
    input  logic         rd_start,
    input  logic         rd_end,
    input  logic         hs_in_n,
    input  logic         inte_wr,
    input  logic         inte_val,
    input  logic [W-1:0] port_in,
    output logic [W-1:0] latch,
    output logic         ibf,
    output logic         obf_n,
    output logic         intr,
    output logic         inte
);

    logic hs_q;
    logic hs_fall;
    logic hs_rise;
    logic in_hs;
    logic out_hs;

    // Strobe / acknowledge edge detection
    assign hs_fall = hs_q & ~hs_in_n;
    assign hs_rise = ~hs_q & hs_in_n;
    assign in_hs   = mode1 & dir_in;
    assign out_hs  = mode1 & ~dir_in;

    // Channel state; set events are tested before clear events
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q  <= 1'b1;
            latch <= '0;
            ibf   <= 1'b0;
            obf_n <= 1'b1;
            intr  <= 1'b0;
            inte  <= 1'b0;
        end else begin
            hs_q <= hs_in_n;
            if (clr) begin
                latch <= '0;
                ibf   <= 1'b0;
                obf_n <= 1'b1;
                intr  <= 1'b0;
                inte  <= 1'b0;
            end else begin
                if (inte_wr) begin
                    inte <= inte_val;
                end
                if (in_hs) begin
                    // A new strobe overwrites the latch even if IBF is still set
                    if (hs_fall) begin
                        latch <= port_in;
                    end
                    if (hs_fall) begin
                        ibf <= 1'b1;
                    end else if (rd_end) begin
                        ibf <= 1'b0;
                    end
                    if (hs_rise) begin
                        intr <= inte;
                    end else if (rd_start) begin
                        intr <= 1'b0;
                    end
                end else if (out_hs) begin
                    if (port_wr) begin
                        latch <= wr_data;
                    end
                    if (port_wr) begin
                        obf_n <= 1'b0;
                    end else if (hs_fall) begin
                        obf_n <= 1'b1;
                    end
                    if (hs_rise) begin
                        intr <= inte;
                    end else if (port_wr) begin
                        intr <= 1'b0;
                    end
                end else begin
                    if (port_wr) begin
                        latch <= wr_data;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ppi_hs.sv
// ppi_hs: parallel port with two W-bit ports (A, B) and an 8-bit port C.
// Mode 0 is plain registered I/O; mode 1 adds a strobed handshake per group
// with interrupt requests; port C supports single-bit set/reset.
//   clk, reset         : clock and synchronous active-high reset
//   bus                : host bus (ppi_hs_if.slave)
//   pa_in/pa_out/pa_oe : port A pins, single drive enable
//   pb_in/pb_out/pb_oe : port B pins, single drive enable
//   pc_in/pc_out/pc_oe : port C pins, per-bit drive enable
//   intr_a, intr_b     : group interrupt requests
module ppi_hs
    import ppi_pkg::*;
#(
    parameter int unsigned W        = 8,
    parameter logic [7:0]  RST_MODE = RST_MODE_DEF
) (
    input  logic         clk,
    input  logic         reset,
    ppi_hs_if.slave      bus,
    input  logic [W-1:0] pa_in,
    output logic [W-1:0] pa_out,
    output logic         pa_oe,
    input  logic [W-1:0] pb_in,
    output logic [W-1:0] pb_out,
    output logic         pb_oe,
    input  logic [7:0]   pc_in,
    output logic [7:0]   pc_out,
    output logic [7:0]   pc_oe,
    output logic         intr_a,
    output logic         intr_b
);

    mode_word_t   mode_q;
    logic         wr_q;
    logic         rd_q;
    logic         cs_n_q;
    logic [1:0]   rd_addr_q;
    logic [7:0]   pc_latch;

    logic         wr_ev;
    logic         rd_start;
    logic         rd_end;
    logic [7:0]   cw;
    logic         ctrl_wr;
    logic         mode_set;
    logic         bsr_wr;
    logic [2:0]   bsr_idx;
    logic         bsr_val;
    logic         a_m1;
    logic         b_m1;
    logic         inte_wr_a;
    logic         inte_wr_b;
    logic         pc_bit_wr;
    logic         pc_wr;
    logic         hs_a_n;

    logic         ibf_a;
    logic         obf_n_a;
    logic         inte_a;
    logic         ibf_b;
    logic         obf_n_b;
    logic         inte_b;

    logic [7:0]   pc_out_c;
    logic [7:0]   pc_oe_c;
    logic [7:0]   pc_rd_c;
    logic [W-1:0] rd_data_c;

    // Host strobe edge detection: one event per strobe
    assign wr_ev    = ~bus.cs_n & ~bus.wr_n & wr_q;
    assign rd_start = ~bus.cs_n & ~bus.rd_n & rd_q;
    assign rd_end   = bus.rd_n & ~rd_q & ~cs_n_q;

    // Control word decode
    assign cw       = bus.din[7:0];
    assign ctrl_wr  = wr_ev & (bus.a == ADDR_CTRL);
    assign mode_set = ctrl_wr & cw[CW_SEL_BIT];
    assign bsr_wr   = ctrl_wr & ~cw[CW_SEL_BIT];
    assign bsr_idx  = bsr_bit_idx(cw);
    assign bsr_val  = cw[0];
    assign a_m1     = grp_a_mode1(mode_q);
    assign b_m1     = mode_q.b_mode;

    // In mode 1 the STB/ACK bit set/reset targets INTE, not the PC latch
    assign inte_wr_a = bsr_wr & a_m1 &
                       ((mode_q.pa_in  & (bsr_idx == 3'(PC_STB_A))) |
                        (~mode_q.pa_in & (bsr_idx == 3'(PC_ACK_A))));
    assign inte_wr_b = bsr_wr & b_m1 & (bsr_idx == 3'(PC_STB_B));
    assign pc_bit_wr = bsr_wr & ~inte_wr_a & ~inte_wr_b;
    assign pc_wr     = wr_ev & (bus.a == ADDR_PC);

    // Group A handshake input depends on its direction
    assign hs_a_n = mode_q.pa_in ? pc_in[PC_STB_A] : pc_in[PC_ACK_A];

    ppi_hs_chan #(.W(W)) u_chan_a (
        .clk      (clk),
        .reset    (reset),
        .mode1    (a_m1),
        .dir_in   (mode_q.pa_in),
        .clr      (mode_set),
        .port_wr  (wr_ev & (bus.a == ADDR_PA)),
        .wr_data  (bus.din),
        .rd_start (rd_start & (bus.a == ADDR_PA)),
        .rd_end   (rd_end & (rd_addr_q == ADDR_PA)),
        .hs_in_n  (hs_a_n),
        .inte_wr  (inte_wr_a),
        .inte_val (bsr_val),
        .port_in  (pa_in),
        .latch    (pa_out),
        .ibf      (ibf_a),
        .obf_n    (obf_n_a),
        .intr     (intr_a),
        .inte     (inte_a)
    );

    ppi_hs_chan #(.W(W)) u_chan_b (
        .clk      (clk),
        .reset    (reset),
        .mode1    (b_m1),
        .dir_in   (mode_q.pb_in),
        .clr      (mode_set),
        .port_wr  (wr_ev & (bus.a == ADDR_PB)),
        .wr_data  (bus.din),
        .rd_start (rd_start & (bus.a == ADDR_PB)),
        .rd_end   (rd_end & (rd_addr_q == ADDR_PB)),
        .hs_in_n  (pc_in[PC_STB_B]),
        .inte_wr  (inte_wr_b),
        .inte_val (bsr_val),
        .port_in  (pb_in),
        .latch    (pb_out),
        .ibf      (ibf_b),
        .obf_n    (obf_n_b),
        .intr     (intr_b),
        .inte     (inte_b)
    );

    // Port C pin view and host read view with handshake overlays
    always_comb begin
        pc_oe_c  = {{4{~mode_q.pch_in}}, {4{~mode_q.pcl_in}}};
        pc_out_c = pc_latch;
        if (a_m1) begin
            pc_oe_c[PC_INTR_A]  = 1'b1;
            pc_out_c[PC_INTR_A] = intr_a;
            if (mode_q.pa_in) begin
                pc_oe_c[PC_STB_A]  = 1'b0;
                pc_oe_c[PC_IBF_A]  = 1'b1;
                pc_out_c[PC_IBF_A] = ibf_a;
            end else begin
                pc_oe_c[PC_ACK_A]  = 1'b0;
                pc_oe_c[PC_OBF_A]  = 1'b1;
                pc_out_c[PC_OBF_A] = obf_n_a;
            end
        end
        if (b_m1) begin
            pc_oe_c[PC_INTR_B]  = 1'b1;
            pc_out_c[PC_INTR_B] = intr_b;
            pc_oe_c[PC_STB_B]   = 1'b0;
            pc_oe_c[PC_HS_B]    = 1'b1;
            pc_out_c[PC_HS_B]   = mode_q.pb_in ? ibf_b : obf_n_b;
        end
        // Output bits read back their driven value, input bits the pins
        pc_rd_c = (pc_out_c & pc_oe_c) | (pc_in & ~pc_oe_c);
        if (a_m1) begin
            if (mode_q.pa_in) begin
                pc_rd_c[PC_STB_A] = inte_a;
            end else begin
                pc_rd_c[PC_ACK_A] = inte_a;
            end
        end
        if (b_m1) begin
            pc_rd_c[PC_STB_B] = inte_b;
        end
    end

    // Host read mux; mode 1 ports always return their latch
    always_comb begin
        rd_data_c = '0;
        case (bus.a)
            ADDR_PA: rd_data_c = (a_m1 | ~mode_q.pa_in) ? pa_out : pa_in;
            ADDR_PB: rd_data_c = (b_m1 | ~mode_q.pb_in) ? pb_out : pb_in;
            ADDR_PC: rd_data_c = W'(pc_rd_c);
            default: rd_data_c = W'(mode_q);
        endcase
    end

    // Strobe history and host read path
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q        <= 1'b1;
            rd_q        <= 1'b1;
            cs_n_q      <= 1'b1;
            rd_addr_q   <= ADDR_PA;
            bus.dout    <= '0;
            bus.dout_oe <= 1'b0;
        end else begin
            wr_q        <= bus.wr_n;
            rd_q        <= bus.rd_n;
            cs_n_q      <= bus.cs_n;
            bus.dout_oe <= ~bus.cs_n & ~bus.rd_n;
            if (rd_start) begin
                bus.dout  <= rd_data_c;
                rd_addr_q <= bus.a;
            end
        end
    end

    // Mode register and port C latch
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q   <= mode_word_t'(RST_MODE);
            pc_latch <= '0;
        end else if (mode_set) begin
            mode_q   <= mode_word_t'(cw);
            pc_latch <= '0;
        end else if (pc_wr) begin
            pc_latch <= cw;
        end else if (pc_bit_wr) begin
            pc_latch[bsr_idx] <= bsr_val;
        end
    end

    // Registered pin drive enables and port C outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            pa_oe  <= 1'b0;
            pb_oe  <= 1'b0;
            pc_out <= '0;
            pc_oe  <= '0;
        end else begin
            pa_oe  <= ~mode_q.pa_in;
            pb_oe  <= ~mode_q.pb_in;
            pc_out <= pc_out_c;
            pc_oe  <= pc_oe_c;
        end
    end

endmodule

// File: tb/tb_ppi_hs.sv
// tb_ppi_hs: self-checking bench for ppi_hs. Host reads push their expected
// data into a scoreboard queue that is popped when dout becomes valid.
module tb_ppi_hs;
    import ppi_pkg::*;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] pa_in, pa_out, pb_in, pb_out;
    logic         pa_oe, pb_oe;
    logic [7:0]   pc_in, pc_out, pc_oe;
    logic         intr_a, intr_b;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];

    always #5 clk = ~clk;

    ppi_hs_if #(.W(W)) bus ();

    ppi_hs #(.W(W), .RST_MODE(8'h9B)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .pa_in  (pa_in),
        .pa_out (pa_out),
        .pa_oe  (pa_oe),
        .pb_in  (pb_in),
        .pb_out (pb_out),
        .pb_oe  (pb_oe),
        .pc_in  (pc_in),
        .pc_out (pc_out),
        .pc_oe  (pc_oe),
        .intr_a (intr_a),
        .intr_b (intr_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [W-1:0] data);
        @(negedge clk);
        bus.cs_n = 1'b0;
        bus.wr_n = 1'b0;
        bus.a    = addr;
        bus.din  = data;
        @(negedge clk);
        bus.cs_n = 1'b1;
        bus.wr_n = 1'b1;
    endtask

    // Start a read; the expected value waits in the scoreboard until dout is valid
    task automatic rd_begin(input logic [1:0] addr, input logic [W-1:0] exp, input string tag);
        logic [W-1:0] e;
        string        t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        bus.cs_n = 1'b0;
        bus.rd_n = 1'b0;
        bus.a    = addr;
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, 32'(bus.dout), 32'(e));
        check({t, "_oe"}, 32'(bus.dout_oe), 32'd1);
    endtask

    task automatic rd_finish();
        bus.rd_n = 1'b1;
        bus.cs_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] addr, input logic [W-1:0] exp, input string tag);
        rd_begin(addr, exp, tag);
        rd_finish();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.cs_n = 1'b1;
        bus.rd_n = 1'b1;
        bus.wr_n = 1'b1;
        bus.a    = 2'd0;
        bus.din  = '0;
        pa_in    = 8'hA5;
        pb_in    = 8'h96;
        pc_in    = 8'hD5;
        reset    = 1'b1;
        idle(3);
        check("rst_pa_oe", 32'(pa_oe), 32'd0);
        check("rst_pb_oe", 32'(pb_oe), 32'd0);
        check("rst_pc_oe", 32'(pc_oe), 32'h00);
        check("rst_dout", 32'(bus.dout), 32'h00);
        check("rst_dout_oe", 32'(bus.dout_oe), 32'd0);
        check("rst_intr_a", 32'(intr_a), 32'd0);
        reset = 1'b0;

        // Reset mode: all inputs
        rd(ADDR_PA, 8'hA5, "rd_pa_pins");
        rd(ADDR_PB, 8'h96, "rd_pb_pins");
        rd(ADDR_PC, 8'hD5, "rd_pc_pins");
        rd(ADDR_CTRL, 8'h9B, "rd_ctrl_rst");

        // Mode 0, all outputs
        wr(ADDR_CTRL, 8'h80);
        wr(ADDR_PA, 8'h5A);
        wr(ADDR_PC, 8'hC3);
        wr(ADDR_PB, 8'h11);
        idle(2);
        check("m0_pa_out", 32'(pa_out), 32'h5A);
        check("m0_pa_oe", 32'(pa_oe), 32'd1);
        check("m0_pb_out", 32'(pb_out), 32'h11);
        check("m0_pc_out", 32'(pc_out), 32'hC3);
        check("m0_pc_oe", 32'(pc_oe), 32'hFF);
        rd(ADDR_PA, 8'h5A, "rd_pa_latch");
        rd(ADDR_PC, 8'hC3, "rd_pc_latch");
        rd(ADDR_CTRL, 8'h80, "rd_ctrl_m0");

        // Group A mode 1 input
        wr(ADDR_CTRL, 8'hB0);
        idle(2);
        check("a_in_pa_out_clr", 32'(pa_out), 32'h00);
        check("a_in_pa_oe", 32'(pa_oe), 32'd0);
        check("a_in_pc_oe", 32'(pc_oe), 32'hEF);
        check("a_in_pc_out", 32'(pc_out), 32'h00);
        wr(ADDR_CTRL, 8'h09);
        rd(ADDR_PC, 8'h10, "rd_pc_inte_a");
        pa_in    = 8'h3C;
        pc_in[4] = 1'b0;
        idle(2);
        check("ibf_a_set", 32'(pc_out[5]), 32'd1);
        check("intr_a_before_rise", 32'(intr_a), 32'd0);
        pa_in    = 8'hFF;
        pc_in[4] = 1'b1;
        idle(1);
        check("intr_a_stb_rise", 32'(intr_a), 32'd1);
        idle(1);
        check("pc3_intr_a", 32'(pc_out[3]), 32'd1);
        rd_begin(ADDR_PA, 8'h3C, "rd_pa_strobed");
        check("intr_a_rd_start", 32'(intr_a), 32'd0);
        check("ibf_a_held_in_rd", 32'(pc_out[5]), 32'd1);
        rd_finish();
        idle(1);
        check("ibf_a_rd_end", 32'(pc_out[5]), 32'd0);

        // Group A mode 1 output
        wr(ADDR_CTRL, 8'hA0);
        idle(2);
        check("a_out_pa_oe", 32'(pa_oe), 32'd1);
        check("a_out_pc_oe", 32'(pc_oe), 32'hBF);
        check("a_out_pc_out", 32'(pc_out), 32'h80);
        wr(ADDR_CTRL, 8'h0D);
        wr(ADDR_PA, 8'h77);
        idle(2);
        check("a_out_pa_out", 32'(pa_out), 32'h77);
        check("obf_a_low", 32'(pc_out[7]), 32'd0);
        pc_in[6] = 1'b0;
        idle(2);
        check("obf_a_ack", 32'(pc_out[7]), 32'd1);
        check("intr_a_ack_fall", 32'(intr_a), 32'd0);
        pc_in[6] = 1'b1;
        idle(2);
        check("intr_a_ack_rise", 32'(intr_a), 32'd1);
        rd(ADDR_PC, 8'hC8, "rd_pc_a_out");
        wr(ADDR_PA, 8'h78);
        idle(2);
        check("intr_a_wr_clr", 32'(intr_a), 32'd0);
        check("obf_a_wr_again", 32'(pc_out[7]), 32'd0);

        // STB fall coinciding with read end: set wins, latch overwritten
        wr(ADDR_CTRL, 8'hB0);
        pa_in    = 8'h11;
        pc_in[4] = 1'b0;
        idle(1);
        pc_in[4] = 1'b1;
        idle(2);
        check("ibf_a_first", 32'(pc_out[5]), 32'd1);
        check("intr_a_inte_off", 32'(intr_a), 32'd0);
        pa_in = 8'h22;
        rd_begin(ADDR_PA, 8'h11, "rd_pa_first");
        pc_in[4] = 1'b0;
        rd_finish();
        pc_in[4] = 1'b1;
        idle(2);
        check("ibf_set_beats_clr", 32'(pc_out[5]), 32'd1);
        rd(ADDR_PA, 8'h22, "rd_pa_overwrite");

        // Mode set while OBF_n pending abandons the handshake
        wr(ADDR_CTRL, 8'hA0);
        wr(ADDR_CTRL, 8'h01);
        wr(ADDR_PA, 8'h55);
        idle(2);
        check("pend_obf_low", 32'(pc_out[7]), 32'd0);
        check("pend_pc0_bsr", 32'(pc_out[0]), 32'd1);
        check("pend_pa_out", 32'(pa_out), 32'h55);
        wr(ADDR_CTRL, 8'hA0);
        check("ms_pa_out_next", 32'(pa_out), 32'h00);
        idle(2);
        check("ms_obf_cleared", 32'(pc_out[7]), 32'd1);
        check("ms_intr_a", 32'(intr_a), 32'd0);
        check("ms_pc0_cleared", 32'(pc_out[0]), 32'd0);

        // Group B mode 1 output
        wr(ADDR_CTRL, 8'h84);
        wr(ADDR_CTRL, 8'h05);
        wr(ADDR_PB, 8'h5A);
        idle(2);
        check("b_pb_out", 32'(pb_out), 32'h5A);
        check("b_pb_oe", 32'(pb_oe), 32'd1);
        check("b_pc_oe", 32'(pc_oe), 32'hFB);
        check("b_obf_low", 32'(pc_out[1]), 32'd0);
        pc_in[2] = 1'b0;
        idle(2);
        check("b_obf_ack", 32'(pc_out[1]), 32'd1);
        pc_in[2] = 1'b1;
        idle(2);
        check("b_intr", 32'(intr_b), 32'd1);
        check("b_pc0_intr", 32'(pc_out[0]), 32'd1);
        rd(ADDR_PB, 8'h5A, "rd_pb_m1");

        // Reset in the middle of a strobe and a host write
        wr(ADDR_CTRL, 8'hB0);
        pc_in[4] = 1'b0;
        idle(2);
        check("pre_rst_ibf", 32'(pc_out[5]), 32'd1);
        bus.cs_n = 1'b0;
        bus.wr_n = 1'b0;
        bus.a    = ADDR_PA;
        bus.din  = 8'hFF;
        reset    = 1'b1;
        @(negedge clk);
        check("mrst_pc_out", 32'(pc_out), 32'h00);
        check("mrst_pc_oe", 32'(pc_oe), 32'h00);
        check("mrst_pa_oe", 32'(pa_oe), 32'd0);
        check("mrst_pa_out", 32'(pa_out), 32'h00);
        check("mrst_intr_b", 32'(intr_b), 32'd0);
        check("mrst_dout", 32'(bus.dout), 32'h00);
        check("mrst_dout_oe", 32'(bus.dout_oe), 32'd0);
        reset    = 1'b0;
        bus.cs_n = 1'b1;
        bus.wr_n = 1'b1;
        pc_in[4] = 1'b1;
        idle(1);
        rd(ADDR_CTRL, 8'h9B, "rd_ctrl_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ppi_hs.md
Name: ppi_hs

Overview:
- Parametrised, fully synchronous successor to the team's mode-0 parallel port block.
- Two W-bit ports (A, B) and one 8-bit port C, each with registered direction control.
- Adds per-group strobed handshake mode (mode 1), interrupt requests, and port C single-bit set/reset.
- Sits between the host bus and external pins; separate in/out/oe pin buses feed top-level tristates.

Parameters:
W, 8, width of host data bus and ports A/B (W>=8; control words use din[7:0], upper bits ignored)
RST_MODE, 8'h9B, mode register value after reset (all ports input, both groups mode 0)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cs_n  in  1  chip select, active low
rd_n  in  1  read strobe, active low, synchronous to clk
wr_n  in  1  write strobe, active low, synchronous to clk
a  in  2  register select: 0=PA, 1=PB, 2=PC, 3=control
din  in  W  host write data
dout  out  W  host read data, registered
dout_oe  out  1  host bus drive enable, registered
pa_in / pa_out / pa_oe  in / out / out  W / W / 1  port A pins
pb_in / pb_out / pb_oe  in / out / out  W / W / 1  port B pins
pc_in / pc_out / pc_oe  in / out / out  8 / 8 / 8  port C pins, per-bit oe
intr_a, intr_b  out  1  group interrupt requests (also driven on PC3/PC0)

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high. All pin inputs are synchronous to clk; external synchronisation is the integrator's responsibility.
- Strobe detection:
  - Write event: cycle in which cs_n=0, wr_n=0 and the previous-cycle wr_n=1. Exactly one event per strobe.
  - Read start: same rule on rd_n.
  - Read end: rd_n 0->1 with cs_n=0 in the previous cycle.
- Read data path: dout is loaded on the read-start cycle and is valid from the next cycle. It holds while rd_n=0. dout_oe <= !cs_n & !rd_n.
- Control write (a=3):
  - din[7]=1 is a mode set:
    - [6:5] group A mode: 00=mode0, otherwise mode1.
    - [4] PA dir (1=in). [3] PC[7:4] dir. [2] group B mode. [1] PB dir. [0] PC[3:0] dir.
    - A mode set clears all output latches, IBF, INTR and INTE, and sets OBF_n=1.
  - din[7]=0 is a bit set/reset: bit din[3:1] of the PC latch <= din[0].
    - In mode 1, bit set/reset of PC4 (A in), PC6 (A out) or PC2 (B) writes INTE instead of the latch.
- Reset: mode=RST_MODE. Latches=0. IBF=0, INTR=0, INTE=0, OBF_n=1. All oe=0. dout=0. dout_oe=0.
- Mode 0: the port drives its latch when its direction is output. A read returns pin inputs for input ports and latches for output ports.
- Mode 1 pin map:
  - Group A input: PC4=STB_n (in), PC5=IBF (out), PC3=INTR.
  - Group A output: PC7=OBF_n (out), PC6=ACK_n (in), PC3=INTR.
  - Group B: PC2=STB_n/ACK_n (in), PC1=IBF/OBF_n (out), PC0=INTR.
  - The remaining PC bits follow their group direction bit.
- Mode 1 input:
  - STB_n 1->0: latch port input, IBF=1.
  - STB_n 0->1: INTR=INTE.
  - Read start on the port clears INTR. Read end clears IBF.
- Mode 1 output:
  - Write event to the port: load latch, OBF_n=0, INTR=0.
  - ACK_n 1->0: OBF_n=1.
  - ACK_n 0->1: INTR=INTE.
  - The port drives its latch continuously.
- Port C read in mode 1: handshake bit positions return internal IBF/OBF_n/INTR state; INTE is returned at the STB/ACK position. Port C data writes do not alter handshake bits.
- Simultaneous events:
  - A set event beats a clear event in the same cycle (STB fall with read end keeps IBF=1; write with ACK fall gives OBF_n=0).
  - STB fall with IBF=1 overwrites the latched data.
  - Reset beats everything.
- Mode change mid-handshake: the handshake is abandoned and state is cleared as in a mode set. No partial transfer completes.

Decomposition:
- Package ppi_pkg: register address constants, control-word field positions, RST_MODE default, PC handshake bit indices, mode encodings.
- Sub-module ppi_hs_chan: one handshake channel (dir, mode, INTE, IBF/OBF_n, INTR, data latch, edge detectors). Instantiated twice, for group A and group B.

Test Plan:
- Reset, then read all four addresses -> PA/PB/PC return pin values, control read returns 8'h9B, all oe=0.
- Write 8'h80, then PA=8'h5A, PC=8'hC3 -> pa_out=5A, pc_out=C3, pa_oe=1, pc_oe=FF.
- Write 8'hB0 (A mode1 in), BSR 8'h09 (INTE_A=1); pulse STB_n with pa_in=8'h3C -> IBF=1 on the fall; intr_a=1 after the rise; read PA returns 3C; intr_a=0 at read start; IBF=0 at read end.
- Write 8'hA0, BSR 8'h0D; write PA=8'h77 -> OBF_n=0; ACK_n fall -> OBF_n=1; ACK_n rise -> intr_a=1; next write clears intr_a.
- STB_n fall in the same cycle as a PA read end -> IBF stays 1 and new data is latched.
- Mode set during pending OBF_n=0 -> OBF_n=1, INTR=0, latches=0 next cycle; a mid-strobe reset gives reset values the next cycle.
